// File: rtl/relax_stage_if.sv
// relax_stage_if: input beat bus from the forwarding block into relax_stage.
//   in_valid     beat present on in_1..in_4
//   in_last      beat is the last beat of a pass
//   in_1..in_4   edge words: up[28] wij[27:24] i[23:19] j[18:14] wi[13:7] wj[6:0]
// The master modport drives the beat and the slave modport receives it.
interface relax_stage_if;
  logic        in_valid;
  logic        in_last;
  logic [28:0] in_1;
  logic [28:0] in_2;
  logic [28:0] in_3;
  logic [28:0] in_4;

  modport master (output in_valid, in_last, in_1, in_2, in_3, in_4);
  modport slave  (input  in_valid, in_last, in_1, in_2, in_3, in_4);
endinterface

// File: rtl/relax_stage.sv
// relax_stage: registered Bellman-Ford relaxation stage.
// Each accepted beat evaluates wi + wij < wj on four lanes. Among relaxing lanes
// that share a destination j, only the one with the smallest candidate writes
// (the lowest lane wins a tie). The stage issues distance write-backs and
// forwarded words, and runs a pass/convergence FSM (IDLE, RUN, CHECK, DONE).
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               begin a run (honoured in IDLE or DONE)
//   in_bus              beat input (relax_stage_if.slave)
//   out_valid           registered beat valid
//   wr_en_k/addr_k/data_k  per-lane distance write-back (k = 1..4)
//   fwd_k               forwarded word {up, i, j, wj} to the forwarding block
//   busy, done          FSM in RUN/CHECK, FSM in DONE
//   converged           last pass produced no update
//   pass_cnt            completed passes
module relax_stage #(
  parameter int unsigned MAX_PASS = 31,
  parameter logic [6:0]  INF      = 7'h7F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  relax_stage_if.slave in_bus,
  output logic         out_valid,
  output logic         wr_en_1,
  output logic         wr_en_2,
  output logic         wr_en_3,
  output logic         wr_en_4,
  output logic [4:0]   wr_addr_1,
  output logic [4:0]   wr_addr_2,
  output logic [4:0]   wr_addr_3,
  output logic [4:0]   wr_addr_4,
  output logic [6:0]   wr_data_1,
  output logic [6:0]   wr_data_2,
  output logic [6:0]   wr_data_3,
  output logic [6:0]   wr_data_4,
  output logic [17:0]  fwd_1,
  output logic [17:0]  fwd_2,
  output logic [17:0]  fwd_3,
  output logic [17:0]  fwd_4,
  output logic         busy,
  output logic         done,
  output logic         converged,
  output logic [4:0]   pass_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [4:0] PASS_LIMIT = 5'(MAX_PASS);

  state_t      state, state_nxt;
  logic        upd_flag;
  logic        accept;
  logic        last_pass;

  logic [28:0] w        [4];
  logic [7:0]  cand_raw [4];
  logic [6:0]  cand     [4];
  logic [3:0]  relax;
  logic [3:0]  win;

  logic [3:0]  wr_en_q;
  logic [4:0]  wr_addr_q [4];
  logic [6:0]  wr_data_q [4];
  logic [17:0] fwd_q     [4];

  assign w[0] = in_bus.in_1;
  assign w[1] = in_bus.in_2;
  assign w[2] = in_bus.in_3;
  assign w[3] = in_bus.in_4;

  assign accept = (state == S_RUN) && in_bus.in_valid;

  // Candidate, relax test and same-destination arbitration. A lane loses if any
  // other relaxing lane with the same j has a smaller candidate, or an equal
  // candidate at a lower lane index.
  always_comb begin
    cand_raw = '{default: '0};
    cand     = '{default: '0};
    relax    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand_raw[2'(k)] = {1'b0, w[2'(k)][13:7]} + {4'b0, w[2'(k)][27:24]};
      cand[2'(k)]     = (cand_raw[2'(k)] >= {1'b0, INF}) ? INF : cand_raw[2'(k)][6:0];
      relax[2'(k)]    = w[2'(k)][28] && (w[2'(k)][13:7] != INF) &&
                        (cand[2'(k)] < w[2'(k)][6:0]);
    end
    win = relax;
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned m = 0; m < 4; m++) begin
        if ((m != k) && relax[2'(m)] && (w[2'(m)][18:14] == w[2'(k)][18:14]) &&
            ((cand[2'(m)] < cand[2'(k)]) || ((cand[2'(m)] == cand[2'(k)]) && (m < k))))
          win[2'(k)] = 1'b0;
      end
    end
  end

  assign last_pass = (pass_cnt + 5'd1) == PASS_LIMIT;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && in_bus.in_last) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (!upd_flag || last_pass) ? S_DONE : S_RUN;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Pass bookkeeping and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt  <= '0;
      upd_flag  <= 1'b0;
      converged <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN) || (state_nxt == S_CHECK);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pass_cnt  <= '0;
            upd_flag  <= 1'b0;
            converged <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept && (|win)) upd_flag <= 1'b1;
        end
        S_CHECK: begin
          pass_cnt <= pass_cnt + 5'd1;
          if (!upd_flag)     converged <= 1'b1;
          else if (last_pass) converged <= 1'b0;
          else               upd_flag  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Lane outputs. Address/data fields reload only on accepted beats; enables
  // and forwarded up bits are cleared whenever no beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '{default: '0};
      wr_data_q <= '{default: '0};
      fwd_q     <= '{default: '0};
    end else begin
      out_valid <= accept;
      for (int unsigned k = 0; k < 4; k++) begin
        wr_en_q[2'(k)]      <= accept && win[2'(k)];
        fwd_q[2'(k)][17]    <= accept && win[2'(k)];
        if (accept) begin
          wr_addr_q[2'(k)]      <= w[2'(k)][18:14];
          wr_data_q[2'(k)]      <= win[2'(k)] ? cand[2'(k)] : w[2'(k)][6:0];
          fwd_q[2'(k)][16:0]    <= {w[2'(k)][23:19], w[2'(k)][18:14],
                                    win[2'(k)] ? cand[2'(k)] : w[2'(k)][6:0]};
        end
      end
    end
  end

  assign wr_en_1   = wr_en_q[0];
  assign wr_en_2   = wr_en_q[1];
  assign wr_en_3   = wr_en_q[2];
  assign wr_en_4   = wr_en_q[3];
  assign wr_addr_1 = wr_addr_q[0];
  assign wr_addr_2 = wr_addr_q[1];
  assign wr_addr_3 = wr_addr_q[2];
  assign wr_addr_4 = wr_addr_q[3];
  assign wr_data_1 = wr_data_q[0];
  assign wr_data_2 = wr_data_q[1];
  assign wr_data_3 = wr_data_q[2];
  assign wr_data_4 = wr_data_q[3];
  assign fwd_1     = fwd_q[0];
  assign fwd_2     = fwd_q[1];
  assign fwd_3     = fwd_q[2];
  assign fwd_4     = fwd_q[3];

endmodule

// File: doc/relax_stage.md
# relax_stage

Registered relaxation stage of the pipelined Bellman-Ford datapath, directly downstream of the forwarding block. Each beat takes four forwarding-corrected edge words and evaluates `wi + wij < wj` per lane. It resolves same-destination conflicts between lanes, issues distance write-backs, and returns 18-bit forwarded words to the forwarding block for the next beat. A pass/convergence FSM counts passes and flags termination.

## Interface
- `MAX_PASS`, 31: pass limit (N-1 for 32 nodes).
- `INF`, 7'h7F: distance value meaning unreachable.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; one clock, synchronous, active-high.
- `start` input 1: begin a run (accepted in IDLE or DONE).
- `in_valid` input 1: beat present on `in_1..in_4`.
- `in_last` input 1: qualifies the beat as the last beat of a pass.
- `in_1`..`in_4` input 29 each: edge word up[28], wij[27:24], i[23:19], j[18:14], wi[13:7], wj[6:0].
- `out_valid` output 1: registered beat valid.
- `wr_en_1`..`wr_en_4` output 1 each: distance write-back enable per lane.
- `wr_addr_1`..`wr_addr_4` output 5 each: node j.
- `wr_data_1`..`wr_data_4` output 7 each: new distance of j.
- `fwd_1`..`fwd_4` output 18 each: up[17], i[16:12], j[11:7], wj[6:0]. Fed to the forwarding block's forwarded-word inputs.
- `busy` output 1: FSM in RUN or CHECK.
- `done` output 1: FSM in DONE.
- `converged` output 1: last pass produced no update (valid while `done`).
- `pass_cnt` output 5: completed passes.

## Operation
- A beat is accepted only when FSM=RUN and `in_valid`=1. Beats in any other state are dropped, with no writes and `out_valid` 0.
- Per lane k, compute `cand_k = wi + wij` as 8-bit; `cand_k >= INF` saturates to INF.
- Lane k relaxes iff up=1, wi≠INF, and cand_k < wj (unsigned 7-bit compare against saturated cand).
- Conflict resolution applies among relaxing lanes with equal j:
  - The lane with the smallest cand wins.
  - On a tie, the lowest lane index wins.
  - Losers do not write.
- Winner lane: `wr_en`=1, `wr_addr`=j, `wr_data`=cand, `fwd` = {1, i, j, cand}.
- Non-winner lane: `wr_en`=0, `fwd` = {0, i, j, wj}. `wr_addr`/`wr_data` still carry j/wj.
- `upd_flag` is set by any accepted beat with at least one winner. It is cleared on entry to RUN.
- FSM states are IDLE, RUN, CHECK, DONE:
  - IDLE: `start` → RUN; clear `pass_cnt`, `upd_flag`, `converged`.
  - RUN: an accepted beat with `in_last`=1 → CHECK. That beat's updates count toward this pass.
  - CHECK (exactly 1 cycle), `pass_cnt` increments:
    - If `upd_flag`=0 → DONE with `converged`=1.
    - Else if the incremented `pass_cnt` = MAX_PASS → DONE with `converged`=0.
    - Else → RUN with `upd_flag` cleared.
  - DONE: hold outputs. `start` → RUN with the same clearing as IDLE.
- `start` in RUN/CHECK is ignored.

## Timing
- All outputs are registered.
- Reset values: `out_valid`, all `wr_en`, `busy`, `done`, `converged` = 0; `pass_cnt` = 0; all `wr_addr`/`wr_data`/`fwd` = 0; FSM = IDLE; `upd_flag` = 0.
- Latency is 1 cycle: a beat accepted at edge n appears on `out_valid`/`wr_*`/`fwd_*` after edge n+1.
- Throughput is one beat per cycle. There is no backpressure; the upstream must hold beats during CHECK.
- `fwd_*` up bits are 0 in any cycle where `out_valid`=0.
- `busy` rises the cycle after `start` is sampled. `done` rises the cycle after CHECK decides termination.
- `rst` wins over all other inputs in the same cycle: an in-flight beat is discarded and `start` is ignored.
- Mid-run `rst` returns to IDLE with reset values after one edge.
- `pass_cnt` cannot wrap: MAX_PASS ≤ 31 terminates first.

## Test plan
- Single lane: lane1 up=1, wij=3, i=0, j=2, wi=5, wj=INF in RUN. Next cycle: `wr_en_1`=1, `wr_addr_1`=2, `wr_data_1`=8, `fwd_1`=18'h2_0108 ({1,0,2,8}).
- Conflict: lanes 2 and 3 both j=4 with cand 9 and 6. Lane3 writes 6; lane2 `wr_en`=0 and `fwd` up=0. Retest with equal cand 6/6: lane2 wins.
- No-relax cases, each giving `wr_en`=0:
  - wi=INF, wij=1.
  - cand=wj (5=5).
  - up=0.
  - wi=7'h7E, wij=4, which saturates to INF.
- Convergence: `start`, one pass of 2 beats with updates and `in_last` on the second, then a pass with no updates. `pass_cnt`=2, `done`=1, `converged`=1.
- Limit: MAX_PASS=3, every pass updates. `done` after the third CHECK with `converged`=0 and `pass_cnt`=3. Beats offered during CHECK and DONE produce no writes.
- Reset: assert `rst` in the same cycle as a relaxing beat mid-pass. Next cycle all outputs are at reset values and the FSM is IDLE. `start` then begins a clean run with `pass_cnt`=0.
